// File: rtl/connect_rr_pick.sv
// -----------------------------------------------------------------------------
// connect_rr_pick
// Combinational round-robin search for connect_arbiter.
// Picks the first channel whose valid bit is set. The search starts at
// ptr_i+1, wraps modulo CONNECT_NUM, and visits ptr_i itself last.
//
// Ports
//   valid_i      [CONNECT_NUM-1:0]  per-channel request
//   ptr_i        [INDEX_WIDTH-1:0]  last granted channel
//   grant_idx_o  [INDEX_WIDTH-1:0]  selected channel (0 when none)
//   grant_vld_o                     high when any channel was selected
// -----------------------------------------------------------------------------
module connect_rr_pick #(
    parameter int CONNECT_NUM = 3,
    parameter int INDEX_WIDTH = (CONNECT_NUM > 2) ? $clog2(CONNECT_NUM) : 1
) (
    input  logic [CONNECT_NUM-1:0] valid_i,
    input  logic [INDEX_WIDTH-1:0] ptr_i,
    output logic [INDEX_WIDTH-1:0] grant_idx_o,
    output logic                   grant_vld_o
);

    // One extra bit holds ptr+k, whose largest value is 2*CONNECT_NUM-1.
    logic [INDEX_WIDTH:0]   sum_s;
    logic [INDEX_WIDTH-1:0] cand_s;

    // Walk candidates from farthest to nearest so the nearest valid one wins.
    always_comb begin
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        sum_s       = '0;
        cand_s      = '0;
        for (int k = CONNECT_NUM; k >= 1; k--) begin
            sum_s = {1'b0, ptr_i} + (INDEX_WIDTH + 1)'(k);
            if (sum_s >= (INDEX_WIDTH + 1)'(CONNECT_NUM)) begin
                sum_s = sum_s - (INDEX_WIDTH + 1)'(CONNECT_NUM);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[INDEX_WIDTH-1:0];
            if (valid_i[cand_s]) begin
                grant_idx_o = cand_s;
                grant_vld_o = 1'b1;
            end else begin
                grant_idx_o = grant_idx_o;
                grant_vld_o = grant_vld_o;
            end
        end
    end

endmodule

// File: rtl/connect_arbiter.sv
// -----------------------------------------------------------------------------
// connect_arbiter
// N-to-1 packet arbiter. Round-robin among valid channels while idle; once a
// non-last beat is taken, the grant is locked to that channel until its last
// beat. A single registered output stage gives full throughput, with the
// upstream ready depending combinationally on SEND_READY only.
//
// Ports
//   CLK, RST        clock, asynchronous active-high reset
//   RECEIVE_VALID   [CONNECT_NUM-1:0]             per-channel valid
//   RECEIVE_DATA    [DATA_WIDTH*CONNECT_NUM-1:0]  channel i at slice i
//   RECEIVE_LAST    [CONNECT_NUM-1:0]             per-channel last beat
//   RECEIVE_READY   [CONNECT_NUM-1:0]             per-channel ready (one-hot or 0)
//   SEND_VALID/DATA/LAST/SOURCE                   registered output beat
//   SEND_READY                                    downstream ready
// -----------------------------------------------------------------------------
module connect_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int CONNECT_NUM = 3
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [CONNECT_NUM-1:0]            RECEIVE_VALID,
    input  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA,
    input  logic [CONNECT_NUM-1:0]            RECEIVE_LAST,
    output logic [CONNECT_NUM-1:0]            RECEIVE_READY,
    output logic                              SEND_VALID,
    output logic [DATA_WIDTH-1:0]             SEND_DATA,
    output logic                              SEND_LAST,
    output logic [((CONNECT_NUM > 2) ? $clog2(CONNECT_NUM) : 1)-1:0] SEND_SOURCE,
    input  logic                              SEND_READY
);

    localparam int INDEX_WIDTH = (CONNECT_NUM > 2) ? $clog2(CONNECT_NUM) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    arb_state_t             state_q, state_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
    logic                   send_valid_q, send_valid_d;
    logic [DATA_WIDTH-1:0]  send_data_q, send_data_d;
    logic                   send_last_q, send_last_d;
    logic [INDEX_WIDTH-1:0] send_source_q, send_source_d;

    logic [INDEX_WIDTH-1:0] pick_idx_s;
    logic                   pick_vld_s;
    logic [INDEX_WIDTH-1:0] grant_idx_s;
    logic                   grant_vld_s;
    logic                   load_en_s;
    logic                   xfer_s;
    logic [DATA_WIDTH-1:0]  data_sel_s;

    connect_rr_pick #(
        .CONNECT_NUM (CONNECT_NUM),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_pick (
        .valid_i     (RECEIVE_VALID),
        .ptr_i       (ptr_q),
        .grant_idx_o (pick_idx_s),
        .grant_vld_o (pick_vld_s)
    );

    // Grant selection: locked channel wins regardless of other requests.
    always_comb begin
        grant_idx_s = pick_idx_s;
        grant_vld_s = pick_vld_s;
        case (state_q)
            ST_LOCKED: begin
                grant_idx_s = ptr_q;
                grant_vld_s = RECEIVE_VALID[ptr_q];
            end
            ST_IDLE: begin
                grant_idx_s = pick_idx_s;
                grant_vld_s = pick_vld_s;
            end
            default: begin
                grant_idx_s = pick_idx_s;
                grant_vld_s = pick_vld_s;
            end
        endcase
    end

    // Handshake: ready is suppressed during reset even though the stage is empty.
    always_comb begin
        load_en_s     = !send_valid_q || SEND_READY;
        xfer_s        = load_en_s && grant_vld_s && !RST;
        RECEIVE_READY = '0;
        if (xfer_s) begin
            RECEIVE_READY[grant_idx_s] = 1'b1;
        end else begin
            RECEIVE_READY = '0;
        end
    end

    // Payload mux for the granted channel.
    always_comb begin
        data_sel_s = '0;
        for (int i = 0; i < CONNECT_NUM; i++) begin
            if (grant_idx_s == INDEX_WIDTH'(i)) begin
                data_sel_s = RECEIVE_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                data_sel_s = data_sel_s;
            end
        end
    end

    // Next-state: capture on a transfer, drain when loading nothing, else hold.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        send_valid_d  = send_valid_q;
        send_data_d   = send_data_q;
        send_last_d   = send_last_q;
        send_source_d = send_source_q;
        if (xfer_s) begin
            send_valid_d  = 1'b1;
            send_data_d   = data_sel_s;
            send_last_d   = RECEIVE_LAST[grant_idx_s];
            send_source_d = grant_idx_s;
            ptr_d         = grant_idx_s;
            state_d       = RECEIVE_LAST[grant_idx_s] ? ST_IDLE : ST_LOCKED;
        end else if (load_en_s) begin
            send_valid_d  = 1'b0;
        end else begin
            send_valid_d  = send_valid_q;
        end
    end

    // State and output registers; reset leaves channel 0 with first priority.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            ptr_q         <= INDEX_WIDTH'(CONNECT_NUM - 1);
            send_valid_q  <= 1'b0;
            send_data_q   <= '0;
            send_last_q   <= 1'b0;
            send_source_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            send_valid_q  <= send_valid_d;
            send_data_q   <= send_data_d;
            send_last_q   <= send_last_d;
            send_source_q <= send_source_d;
        end
    end

    assign SEND_VALID  = send_valid_q;
    assign SEND_DATA   = send_data_q;
    assign SEND_LAST   = send_last_q;
    assign SEND_SOURCE = send_source_q;

endmodule

// File: tb/tb_connect_arbiter.sv
// -----------------------------------------------------------------------------
// tb_connect_arbiter
// Directed scenarios followed by random traffic, all compared against a
// behavioural model of the arbitration rules (lock flag, last-grant pointer,
// one output slot).
// -----------------------------------------------------------------------------
module tb_connect_arbiter;

    localparam int DW = 32;
    localparam int N  = 3;
    localparam int IW = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic [N-1:0]      RECEIVE_VALID;
    logic [DW*N-1:0]   RECEIVE_DATA;
    logic [N-1:0]      RECEIVE_LAST;
    logic [N-1:0]      RECEIVE_READY;
    logic              SEND_VALID;
    logic [DW-1:0]     SEND_DATA;
    logic              SEND_LAST;
    logic [IW-1:0]     SEND_SOURCE;
    logic              SEND_READY;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic          m_locked;
    int            m_ptr;
    logic          m_sv;
    logic [DW-1:0] m_sd;
    logic          m_sl;
    int            m_ss;

    connect_arbiter #(
        .DATA_WIDTH  (DW),
        .CONNECT_NUM (N)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RECEIVE_VALID (RECEIVE_VALID),
        .RECEIVE_DATA  (RECEIVE_DATA),
        .RECEIVE_LAST  (RECEIVE_LAST),
        .RECEIVE_READY (RECEIVE_READY),
        .SEND_VALID    (SEND_VALID),
        .SEND_DATA     (SEND_DATA),
        .SEND_LAST     (SEND_LAST),
        .SEND_SOURCE   (SEND_SOURCE),
        .SEND_READY    (SEND_READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_ptr    = N - 1;
        m_sv     = 1'b0;
        m_sd     = '0;
        m_sl     = 1'b0;
        m_ss     = 0;
    endtask

    function automatic logic [DW*N-1:0] pack(input logic [DW-1:0] c0,
                                             input logic [DW-1:0] c1,
                                             input logic [DW-1:0] c2);
        return {c2, c1, c0};
    endfunction

    // Called at a falling edge: drive, check, step one rising edge, update model.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic sr, input logic [DW*N-1:0] d);
        int           g;
        logic         gv;
        logic         le;
        logic [N-1:0] er;
        RECEIVE_VALID = v;
        RECEIVE_LAST  = l;
        SEND_READY    = sr;
        RECEIVE_DATA  = d;
        #1;
        g  = 0;
        gv = 1'b0;
        if (m_locked) begin
            g  = m_ptr;
            gv = v[m_ptr];
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!gv && v[c]) begin
                    g  = c;
                    gv = 1'b1;
                end
            end
        end
        le = !m_sv || sr;
        er = '0;
        if (le && gv) er[g] = 1'b1;
        chk("send_valid",  SEND_VALID,  m_sv);
        chk("send_data",   SEND_DATA,   m_sd);
        chk("send_last",   SEND_LAST,   m_sl);
        chk("send_source", SEND_SOURCE, m_ss);
        chk("recv_ready",  RECEIVE_READY, er);
        chk("ready_onehot", ($countones(RECEIVE_READY) <= 1), 1);
        chk("ready_wo_valid", RECEIVE_READY & ~v, 0);
        @(posedge CLK);
        if (le) begin
            if (gv) begin
                m_sv     = 1'b1;
                m_sd     = d[g*DW +: DW];
                m_sl     = l[g];
                m_ss     = g;
                m_ptr    = g;
                m_locked = !l[g];
            end else begin
                m_sv = 1'b0;
            end
        end
        @(negedge CLK);
    endtask

    // Called at a falling edge: assert reset, check immediate effect, release.
    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("rst_send_valid",  SEND_VALID,    0);
        chk("rst_send_data",   SEND_DATA,     0);
        chk("rst_send_last",   SEND_LAST,     0);
        chk("rst_send_source", SEND_SOURCE,   0);
        chk("rst_ready",       RECEIVE_READY, 0);
        model_reset();
        @(negedge CLK);
        chk("rst_ready_held",  RECEIVE_READY, 0);
        RST = 1'b0;
    endtask

    initial begin
        logic [N-1:0] rv;
        logic [N-1:0] rl;
        logic         rs;
        RST           = 1'b0;
        RECEIVE_VALID = '0;
        RECEIVE_DATA  = '0;
        RECEIVE_LAST  = '0;
        SEND_READY    = 1'b0;
        model_reset();
        @(negedge CLK);
        do_reset();

        // Round-robin with every channel valid and single-beat packets.
        for (int k = 0; k < 6; k++) begin
            cycle(3'b111, 3'b111, 1'b1, pack(32'h1000 + k, 32'h2000 + k, 32'h3000 + k));
            chk("rr_seq_src",   SEND_SOURCE, k % 3);
            chk("rr_seq_valid", SEND_VALID,  1);
        end

        // Park the pointer on channel 0.
        cycle(3'b001, 3'b001, 1'b1, pack(32'h0000_00AA, 32'h0, 32'h0));
        chk("park_src", SEND_SOURCE, 0);

        // Channel 1 three-beat packet amid competing requests.
        for (int b = 0; b < 3; b++) begin
            cycle(3'b111, {1'b1, (b == 2) ? 1'b1 : 1'b0, 1'b1}, 1'b1,
                  pack(32'h0000_0000 + b, 32'h1111_0000 + b, 32'h2222_0000 + b));
            chk("pkt_src",  SEND_SOURCE, 1);
            chk("pkt_data", SEND_DATA,   32'h1111_0000 + b);
            chk("pkt_last", SEND_LAST,   (b == 2) ? 1 : 0);
        end
        cycle(3'b111, 3'b111, 1'b1, pack(32'h0, 32'h0, 32'h2222_00FF));
        chk("pkt_next_src", SEND_SOURCE, 2);

        // Downstream stall holding 0xA5A5A5A5.
        cycle(3'b001, 3'b001, 1'b1, pack(32'hA5A5_A5A5, 32'h0, 32'h0));
        for (int s = 0; s < 4; s++) begin
            cycle(3'b111, 3'b111, 1'b0, pack($urandom, $urandom, $urandom));
            chk("stall_data",  SEND_DATA,     32'hA5A5_A5A5);
            chk("stall_valid", SEND_VALID,    1);
            chk("stall_ready", RECEIVE_READY, 0);
        end
        cycle(3'b111, 3'b111, 1'b1, pack(32'h0, 32'h5555_0001, 32'h0));
        chk("stall_ptr_src", SEND_SOURCE, 1);

        // Only channel 2 requesting, back-to-back single beats.
        for (int i = 0; i < 5; i++) begin
            cycle(3'b100, 3'b100, 1'b1, pack(32'h0, 32'h0, 32'hC000 + i));
            chk("solo_src",  SEND_SOURCE, 2);
            chk("solo_data", SEND_DATA,   32'hC000 + i);
        end

        // Reset while locked on channel 1 after its first beat.
        cycle(3'b010, 3'b000, 1'b1, pack(32'h0, 32'h7777_0001, 32'h0));
        chk("lock_src", SEND_SOURCE, 1);
        RECEIVE_VALID = 3'b111;
        RECEIVE_LAST  = 3'b000;
        do_reset();
        cycle(3'b111, 3'b111, 1'b1, pack(32'h8888_0000, 32'h8888_0001, 32'h8888_0002));
        chk("rst_first_grant", SEND_SOURCE, 0);

        // Random traffic against the model, with occasional resets.
        for (int t = 0; t < 400; t++) begin
            rv = 3'($urandom_range(0, 7));
            rl = 3'($urandom_range(0, 7));
            rs = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end
            cycle(rv, rl, rs, pack($urandom, $urandom, $urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/connect_arbiter.md
CONNECT_ARBITER -- requirements
Module: connect_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width per channel.
REQ-002 Parameter CONNECT_NUM, default 3: number of receive channels, legal range 2 to 16.
REQ-003 Localparam INDEX_WIDTH SHALL equal max(1, clog2(CONNECT_NUM)).
REQ-004 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 RST  input  1  reset; asynchronous, active-high.
REQ-006 RECEIVE_VALID  input  CONNECT_NUM  per-channel valid.
REQ-007 RECEIVE_DATA  input  DATA_WIDTH*CONNECT_NUM  channel i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
REQ-008 RECEIVE_LAST  input  CONNECT_NUM  final beat of a packet on channel i.
REQ-009 RECEIVE_READY  output  CONNECT_NUM  per-channel ready; at most one bit high.
REQ-010 SEND_VALID  output  1  registered output valid.
REQ-011 SEND_DATA  output  DATA_WIDTH  registered payload.
REQ-012 SEND_LAST  output  1  registered last flag.
REQ-013 SEND_SOURCE  output  INDEX_WIDTH  registered index of the originating channel.
REQ-014 SEND_READY  input  1  downstream ready.

Function
REQ-015 A transfer on channel i SHALL occur in a cycle where RECEIVE_VALID[i] and RECEIVE_READY[i] are both high; a send transfer SHALL occur in a cycle where SEND_VALID and SEND_READY are both high.
REQ-016 Load enable SHALL be: !SEND_VALID || SEND_READY; this gives one output stage with full throughput and a combinational ready path from SEND_READY only.
REQ-017 RECEIVE_READY[i] SHALL be high only when load enable is high, channel i is granted, and RECEIVE_VALID[i] is high.
REQ-018 On a receive transfer, the output registers SHALL capture data, last and source on the same edge; latency SHALL be one cycle from input to SEND_*.
REQ-019 When load enable is high and no receive transfer occurs, SEND_VALID SHALL clear on the next edge.
REQ-020 Arbitration state: two states, IDLE and LOCKED, plus a pointer PTR (INDEX_WIDTH bits) holding the last granted channel.
REQ-021 In IDLE, the grant SHALL go to the first channel with valid high, searching PTR+1, PTR+2, … and wrapping modulo CONNECT_NUM; PTR itself is searched last.
REQ-022 In LOCKED, the grant SHALL be fixed at PTR whatever the other valids are.
REQ-023 A transfer with RECEIVE_LAST low SHALL set PTR to the granted index and enter LOCKED.
REQ-024 A transfer with RECEIVE_LAST high SHALL set PTR to the granted index and enter (or stay in) IDLE.
REQ-025 Without a transfer, the state and PTR SHALL hold; the grant may change between cycles only while in IDLE.
REQ-026 No valid input SHALL result in no grant, all RECEIVE_READY low, and PTR unchanged.
REQ-027 Wrap-around: the search after PTR = CONNECT_NUM-1 SHALL begin at channel 0.
REQ-028 In LOCKED, if the locked channel drops its valid, the lock SHALL be held and no other channel granted; this is a legal stall.

Reset
REQ-029 Asserting RST SHALL immediately set SEND_VALID=0, SEND_LAST=0, SEND_DATA=0, SEND_SOURCE=0, state=IDLE, PTR=CONNECT_NUM-1, so channel 0 has first priority.
REQ-030 RESET mid-packet SHALL discard the lock and any buffered beat; RECEIVE_READY SHALL be all low while RST is high.

Structure
REQ-031 No shared package SHALL be used; DATA_WIDTH and CONNECT_NUM SHALL remain module parameters, matching the other connect_* blocks.
REQ-032 The round-robin search SHALL live in one combinational sub-module, connect_rr_pick (inputs: valid vector, PTR; outputs: grant index, grant-valid).

Verification
REQ-033 After reset, VALID=3'b111 with LAST=3'b111 and SEND_READY=1 held: SEND_SOURCE SHALL sequence 0,1,2,0,… and SEND_VALID SHALL stay high every cycle from cycle 1.
REQ-034 Channel 1 sends a 3-beat packet (LAST on beat 3) while channel 0 and channel 2 stay valid: all 3 beats SHALL leave with SEND_SOURCE=1 back-to-back, and the next grant SHALL go to channel 2.
REQ-035 SEND_READY=0 for 4 cycles while SEND_VALID=1 with data 0xA5A5A5A5: SEND_DATA SHALL hold, all RECEIVE_READY SHALL stay 0, and PTR SHALL be unchanged.
REQ-036 Only channel 2 valid, 5 single-beat transfers: each SHALL be accepted back-to-back, SEND_SOURCE=2 on all five.
REQ-037 RST pulsed while LOCKED on channel 1 after beat 1 of 3: SEND_VALID SHALL be 0 immediately, and after release with all channels valid the first grant SHALL be channel 0.
REQ-038 Every cycle of every test: at most one RECEIVE_READY bit high, and no RECEIVE_READY high while its RECEIVE_VALID is low.
